// File: rtl/alu_seq_core.sv
// alu_seq_core: multi-cycle ALU with a start/busy/done handshake.
// Ports: clk, rst, start, op, a_in, b_in, led_sel -> busy, done, result, flags, led.
module alu_seq_core #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       led_sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [7:0]       led
);

  if (WIDTH != 8 && WIDTH != 16 && WIDTH != 32) begin : g_bad_width
    $error("alu_seq_core: WIDTH must be 8, 16 or 32");
  end

  localparam int CW = SHW + 1;
  localparam int M  = WIDTH - 1;
  localparam logic [3:0] NBYTES = 4'(WIDTH / 8);

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2:0]         op_q;
  logic [CW-1:0]      cnt;
  // SLL: low half is the shifting value, bit WIDTH is the last bit out.
  // MUL: {hi, lo} product register, lo starts as the multiplier.
  logic [2*WIDTH-1:0] acc;

  logic [SHW-1:0]     shamt;
  logic [CW-1:0]      n_exec;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [WIDTH-1:0]   res_d;
  logic               c_d;
  logic               v_d;
  logic [WIDTH-1:0]   res_shr;

  assign shamt = b_q[SHW-1:0];

  always_comb begin
    n_exec = CW'(1);
    if (op_q == OP_MUL)
      n_exec = CW'(WIDTH);
    else if (op_q == OP_SLL && shamt != '0)
      n_exec = {1'b0, shamt};
  end

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, a_q} : '0);
  assign add_s = {1'b0, a_q} + {1'b0, b_q};
  assign sub_s = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);

  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    case (op_q)
      3'b000: res_d = a_q & b_q;
      3'b001: res_d = a_q | b_q;
      3'b010: res_d = a_q ^ b_q;
      3'b011: res_d = ~(a_q | b_q);
      OP_ADD: begin
        res_d = add_s[WIDTH-1:0];
        c_d   = add_s[WIDTH];
        v_d   = (a_q[M] == b_q[M]) && (res_d[M] != a_q[M]);
      end
      OP_SUB: begin
        res_d = sub_s[WIDTH-1:0];
        c_d   = sub_s[WIDTH];
        v_d   = (a_q[M] != b_q[M]) && (res_d[M] != a_q[M]);
      end
      OP_SLL: begin
        res_d = acc[WIDTH-1:0];
        c_d   = acc[WIDTH];
      end
      default: begin
        res_d = acc[WIDTH-1:0];
        c_d   = |acc[2*WIDTH-1:WIDTH];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      flags  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cnt    <= '0;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= a_in;
            b_q   <= b_in;
            op_q  <= op;
            cnt   <= '0;
            acc   <= {{WIDTH{1'b0}},
                      (op == OP_MUL) ? b_in : a_in};
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == n_exec) begin
            result <= res_d;
            flags  <= {res_d == '0, c_d, v_d, res_d[M]};
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
            if (op_q == OP_MUL)
              acc <= {mul_sum, acc[WIDTH-1:1]};
            else if (op_q == OP_SLL && cnt < {1'b0, shamt})
              acc <= acc << 1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign res_shr = result >> {led_sel, 3'b000};
  assign led = ({1'b0, led_sel} < NBYTES) ? res_shr[7:0]
             : {4'b0000, flags};

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed-vector bench for alu_seq_core (WIDTH=32).
// Drives on falling edges, samples on falling edges.
module tb_alu_seq_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [2:0]  led_sel;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  flags;
  logic [7:0]  led;

  int vectors = 0;
  int miscompares = 0;

  alu_seq_core #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a_in    (a_in),
    .b_in    (b_in),
    .led_sel (led_sel),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .flags   (flags),
    .led     (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Runs one op; lat counts falling-edge samples from the first
  // cycle after the start edge up to and including the done cycle.
  task automatic run_op(input string tag,
                        input logic [2:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int exp_lat,
                        input logic [31:0] exp_r,
                        input logic [3:0] exp_f,
                        input bit disturb);
    int i;
    int nb;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    op = o;
    a_in = a;
    b_in = b;
    i = 0;
    nb = 0;
    seen = 1'b0;
    while (!seen && i < 100) begin
      @(negedge clk);
      i++;
      if (i == 1) start = 1'b0;
      if (busy) nb++;
      if (done) seen = 1'b1;
      if (disturb && i == 5) begin
        start = 1'b1;
        op = 3'b100;
        a_in = 32'h1234_5678;
        b_in = 32'h0000_0001;
      end
      if (disturb && i == 6) start = 1'b0;
    end
    chk({tag, ".lat"}, i, exp_lat);
    chk({tag, ".busy"}, nb, exp_lat);
    chk({tag, ".res"}, result, exp_r);
    chk({tag, ".flg"}, {28'd0, flags}, {28'd0, exp_f});
    @(negedge clk);
    chk({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int p1;
    int p2;
    int nd;
    rst = 1'b1;
    start = 1'b0;
    op = 3'b000;
    a_in = '0;
    b_in = '0;
    led_sel = 3'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.out", {busy, done, flags, 26'd0},
        32'd0);
    chk("rst.res", result, 32'd0);
    chk("rst.led", {24'd0, led}, 32'd0);
    rst = 1'b0;

    run_op("add", 3'b100, 32'h7FFF_FFFF, 32'h1,
           3, 32'h8000_0000, 4'b0011, 1'b0);
    led_sel = 3'd3;
    #1 chk("add.led3", {24'd0, led}, 32'h80);
    led_sel = 3'd4;
    #1 chk("add.led4", {24'd0, led}, 32'h03);

    run_op("sub0", 3'b101, 32'h5, 32'h5,
           3, 32'h0, 4'b1100, 1'b0);
    led_sel = 3'd7;
    #1 chk("sub0.led7", {24'd0, led}, 32'h0C);
    run_op("sub1", 3'b101, 32'h0, 32'h1,
           3, 32'hFFFF_FFFF, 4'b0001, 1'b0);

    run_op("sll1", 3'b110, 32'h8000_0001, 32'h1,
           3, 32'h0000_0002, 4'b0100, 1'b0);
    run_op("sll4", 3'b110, 32'h8000_0001, 32'h4,
           6, 32'h0000_0010, 4'b0000, 1'b0);
    run_op("sll0", 3'b110, 32'h8000_0001, 32'h20,
           3, 32'h8000_0001, 4'b0001, 1'b0);

    run_op("mul0", 3'b111, 32'h0001_0000, 32'h0001_0000,
           34, 32'h0, 4'b1100, 1'b0);
    run_op("mul1", 3'b111, 32'h0000_FFFF, 32'h0000_FFFF,
           34, 32'hFFFE_0001, 4'b0001, 1'b0);

    run_op("or", 3'b001, 32'h0F0F_0000, 32'h0000_00F0,
           3, 32'h0F0F_00F0, 4'b0000, 1'b0);
    run_op("xor", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           3, 32'h0, 4'b1000, 1'b0);
    led_sel = 3'd0;
    #1 chk("xor.led0", {24'd0, led}, 32'h00);

    run_op("mulx", 3'b111, 32'h0001_0000, 32'h0001_0000,
           34, 32'h0, 4'b1100, 1'b1);
    run_op("nor", 3'b011, 32'h0, 32'h0,
           3, 32'hFFFF_FFFF, 4'b0001, 1'b0);
    led_sel = 3'd1;
    #1 chk("nor.led1", {24'd0, led}, 32'hFF);

    // start held high: DONE must not chain straight into EXEC
    @(negedge clk);
    start = 1'b1;
    op = 3'b100;
    a_in = 32'd1;
    b_in = 32'd2;
    p1 = 0;
    p2 = 0;
    for (int i = 1; i <= 30 && p2 == 0; i++) begin
      @(negedge clk);
      if (done) begin
        if (p1 == 0) p1 = i;
        else p2 = i;
      end
    end
    start = 1'b0;
    chk("b2b.first", p1, 3);
    chk("b2b.gap", p2 - p1, 4);
    chk("b2b.res", result, 32'd3);
    repeat (3) @(negedge clk);
    chk("b2b.idle", {31'd0, busy}, 32'd0);

    // reset during the tenth EXEC cycle of a MUL
    @(negedge clk);
    start = 1'b1;
    op = 3'b111;
    a_in = 32'h0001_0000;
    b_in = 32'h0001_0000;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    rst = 1'b1;
    led_sel = 3'd4;
    @(negedge clk);
    chk("mrst.bd", {30'd0, busy, done}, 32'd0);
    chk("mrst.res", result, 32'd0);
    chk("mrst.flg", {28'd0, flags}, 32'd0);
    chk("mrst.led", {24'd0, led}, 32'd0);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("mrst.quiet", nd, 0);

    run_op("and", 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00,
           3, 32'hF000_F000, 4'b0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
- Parametrised, multi-cycle successor to the switch-driven ALU top.
- Captures two WIDTH-bit operands and a 3-bit opcode on a start pulse, then runs the operation:
  - logic, add and subtract finish in one execute cycle;
  - shift-left is iterative;
  - multiply is shift-add.
- Returns a registered result and flags with a busy/done handshake.
- An 8-bit LED view selects one result byte or the flag nibble, for board display.

Parameters:
- WIDTH, 32, operand/result width. Legal values are 8, 16 and 32. Any other value is a design error and must be caught with an elaboration-time check.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b_in.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only in IDLE.
- op  in  3  opcode, captured with start.
- a_in  in  WIDTH  operand A, captured with start.
- b_in  in  WIDTH  operand B, captured with start.
- led_sel  in  3  LED view select. Combinational, usable at any time.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse marking result/flags updated.
- result  out  WIDTH  registered result, held until the next done.
- flags  out  4  registered {Z,C,V,N}, held until the next done.
- led  out  8  byte view of result/flags.

Behaviour:
- Reset:
  - state IDLE; busy=0, done=0, result=0, flags=0, internal operand/counter registers 0; led therefore 0.
  - Reset mid-operation aborts: no done, and result/flags are cleared to 0.
- FSM states are IDLE, EXEC and DONE.
  - IDLE to EXEC: start=1 at edge T0; a_in, b_in and op are latched at that edge.
  - EXEC to DONE: when the op's execute count is complete.
  - DONE to IDLE: unconditionally, after 1 cycle. done=1 only in DONE. Result and flags are written on entry to DONE.
- start outside IDLE is ignored; no queuing.
- Operand and op changes after T0 have no effect on the running operation.
- Execute cycles per op (start at T0 gives done high in the cycle after edge T0+1+N):
  - ops 000–101: N=1.
  - op 110 (SLL): N = max(1, b[SHW-1:0]).
  - op 111 (MUL): N = WIDTH.
- Op 000 AND, op 001 OR, op 010 XOR, op 011 NOR:
  - result = bitwise op; C=0, V=0.
- Op 100 ADD:
  - result = (a+b) mod 2^WIDTH.
  - C = carry out.
  - V = signed overflow, i.e. a[MSB]==b[MSB] and result[MSB]!=a[MSB].
- Op 101 SUB:
  - result = a + ~b + 1.
  - C = carry out of that sum, so 1 means no borrow.
  - V = a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
- Op 110 SLL:
  - Shifts a one bit per EXEC cycle, b[SHW-1:0] times; upper bits of b are ignored.
  - Shift amount 0: result = a, C=0.
  - Otherwise C = last bit shifted out of the MSB. V=0.
- Op 111 MUL:
  - Unsigned 2·WIDTH-bit product via iterative shift-add; result = low WIDTH bits.
  - C = 1 iff the high WIDTH bits are nonzero. V=0.
- All ops: Z = (result==0); N = result[WIDTH-1].
- LED view:
  - led_sel < WIDTH/8: led = result[8·led_sel+7 : 8·led_sel].
  - Otherwise: led = {4'b0000, Z, C, V, N}.
  - For WIDTH=32, sel 4–7 show flags. For WIDTH=8, sel 1–7 show flags.

Test Plan:
- Boundary value: SHW is taken to be $clog2(WIDTH) for all directed cases.
- WIDTH=32, ADD a=0x7FFFFFFF, b=0x00000001:
  - done in the cycle after T0+2; result=0x80000000; flags Z0 C0 V1 N1.
  - led_sel=3 gives led=0x80; led_sel=4 gives led=0x03.
- SUB a=b=0x00000005:
  - result=0, Z=1, C=1, V=0, N=0; led_sel=7 gives led=0x0C.
  - Then SUB a=0, b=1: result=0xFFFFFFFF, C=0, N=1.
- SLL a=0x80000001:
  - b=1: result=0x00000002, C=1, done after T0+2.
  - b=4: result=0x00000010, C=0, done after T0+5.
  - b=0x20 (shift field 0): result=0x80000001, C=0, 1 EXEC cycle.
- MUL 0x00010000 × 0x00010000:
  - busy for 34 cycles; done after T0+33; result=0, Z=1, C=1.
  - MUL 0x0000FFFF × 0x0000FFFF: result=0xFFFE0001, C=0.
- Handshake:
  - During a MUL, pulse start with op=100 and change a_in/b_in: ignored, and the MUL result is unchanged.
  - start asserted in the DONE cycle: ignored.
  - start held high continuously: back-to-back operations, one per IDLE visit.
- Reset mid-MUL (cycle 10 of EXEC):
  - next cycle busy=0, done never pulses, result=0, flags=0, led=0.
  - A fresh AND 0xF0F0F0F0 & 0xFF00FF00 then gives 0xF000F000, N=1.
